// File: rtl/scm16_pkg.sv
// Shared types, widths and bit-order helpers for the SCM16 16-bit word path.
// The receiver and any golden model use the same index and reversal functions.
package scm16_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 5;

    // FILL: 0..15 bits held. PENDING: 16 bits held, waiting for the output slot.
    typedef enum logic {
        ST_FILL    = 1'b0,
        ST_PENDING = 1'b1
    } rx_state_t;

    function automatic logic [WORD_W-1:0] bitrev16(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W; i++) begin
            r[i] = w[WORD_W-1-i];
        end
        return r;
    endfunction

    // Bit position written by the cnt-th received bit.
    function automatic logic [3:0] idx(input logic [CNT_W-1:0] cnt, input logic msb_first);
        logic [3:0] i;
        i = msb_first ? (4'd15 - cnt[3:0]) : cnt[3:0];
        return i;
    endfunction

endpackage

// File: rtl/serdes_rx16_if.sv
// Serial-in / word-out bus of serdes_rx16. The master drives bits and drains words;
// the slave is the receiver.
interface serdes_rx16_if;
    import scm16_pkg::*;

    // Both sides use strict valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both 1; valid and its data hold steady until that edge.
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [WORD_W-1:0] out_word;
    logic              out_ready;
    logic [CNT_W-1:0]  bit_cnt;
    rx_state_t         state;

    modport master (
        output in_valid, in_bit, flush, out_ready,
        input  in_ready, out_valid, out_word, bit_cnt, state
    );

    modport slave (
        input  in_valid, in_bit, flush, out_ready,
        output in_ready, out_valid, out_word, bit_cnt, state
    );

endinterface

// File: rtl/serdes_rx16_slot.sv
// One-entry valid/ready holding register for assembled words. Supports load,
// stall, and load-while-draining so consecutive words leave without a bubble.
module serdes_rx16_slot
    import scm16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    output logic              can_load,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word
);

    assign can_load = !out_valid || out_ready;

    // out_word keeps its last value after a drain; only a load changes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_word  <= load_word;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serdes_rx16.sv
// Serial-to-parallel receiver: assembles 16 accepted bits into a word, LSB-first or
// MSB-first by parameter, and hands it to a one-entry output slot.
module serdes_rx16
    import scm16_pkg::*;
#(
    parameter int UUID      = 0,
    parameter     NAME      = "",
    parameter bit MSB_FIRST = 1'b0
) (
    input logic          clk,
    input logic          rst,
    serdes_rx16_if.slave bus
);

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic              accept;
    logic              xfer;
    logic              slot_can_load;
    logic              unused_params;

    assign unused_params = ^{32'(UUID), 32'($bits(NAME))};

    // in_ready depends on registered state only, never on out_ready.
    assign bus.in_ready = (cnt_q != CNT_W'(WORD_W));
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
    assign xfer         = (state_q == ST_PENDING) && slot_can_load && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    // flush outranks both a bit accept and a pending transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        if (bus.flush) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            sh_d    = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        sh_d[idx(cnt_q, MSB_FIRST)] = bus.in_bit;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WORD_W - 1)) begin
                            state_d = ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (xfer) begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                        sh_d    = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            endcase
        end
    end

    assign bus.bit_cnt = cnt_q;
    assign bus.state   = state_q;

    serdes_rx16_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (xfer),
        .load_word (sh_q),
        .can_load  (slot_can_load),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_word  (bus.out_word)
    );

endmodule

// File: tb/tb_serdes_rx16.sv
// Bench for serdes_rx16: an LSB-first and an MSB-first instance share one stimulus
// stream; each has its own expected-word queue checked whenever a word is drained.
module tb_serdes_rx16;
    import scm16_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_bit;
    logic flush;
    logic out_ready;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    serdes_rx16_if bus0();
    serdes_rx16_if bus1();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_bit    = in_bit;
    assign bus0.flush     = flush;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_bit    = in_bit;
    assign bus1.flush     = flush;
    assign bus1.out_ready = out_ready;

    serdes_rx16 #(.UUID(1), .NAME("rx_lsb"), .MSB_FIRST(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    serdes_rx16 #(.UUID(2), .NAME("rx_msb"), .MSB_FIRST(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers / drivers ----------------
    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15-i] = w[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] w);
        exp_q0.push_back(w);
        exp_q1.push_back(rev16(w));
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        while (!bus0.in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!bus0.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_bit_timeout in_ready got=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Stream is always sent word bit 0 first; max_gap adds random idle cycles.
    task automatic send_word(input logic [15:0] w, input int max_gap);
        for (int i = 0; i < 16; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    in_bit = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            send_bit(w[i]);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic monitor_loop();
        logic [15:0] exp_w;
        forever begin
            @(negedge clk);
            if (rst) begin
                total++;
                if ((bus0.in_ready && bus0.bit_cnt == 5'd16) || bus0.bit_cnt > 5'd16 ||
                    (bus1.in_ready && bus1.bit_cnt == 5'd16) || bus1.bit_cnt > 5'd16) begin
                    bad++;
                    $display("FAIL ready_cnt_invariant got in_ready=%0b/%0b cnt=%0d/%0d required cnt<=16 and no ready at 16",
                             bus0.in_ready, bus1.in_ready, bus0.bit_cnt, bus1.bit_cnt);
                end
                if (bus0.out_valid && out_ready) begin
                    total++;
                    if (exp_q0.size() == 0) begin
                        bad++;
                        $display("FAIL lsb_unexpected_word got=%h required=none", bus0.out_word);
                    end else begin
                        exp_w = exp_q0.pop_front();
                        if (bus0.out_word !== exp_w) begin
                            bad++;
                            $display("FAIL lsb_word got=%h required=%h", bus0.out_word, exp_w);
                        end
                    end
                end
                if (bus1.out_valid && out_ready) begin
                    total++;
                    if (exp_q1.size() == 0) begin
                        bad++;
                        $display("FAIL msb_unexpected_word got=%h required=none", bus1.out_word);
                    end else begin
                        exp_w = exp_q1.pop_front();
                        if (bus1.out_word !== exp_w) begin
                            bad++;
                            $display("FAIL msb_word got=%h required=%h", bus1.out_word, exp_w);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || bus0.out_valid) && n < 400) begin
            tick();
            n++;
        end
        total++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending got=%0d/%0d required=0/0", name, exp_q0.size(), exp_q1.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b/%b required=0/0", bus0.out_valid, bus1.out_valid);
        end
        total++;
        if (bus0.out_word !== 16'h0000 || bus1.out_word !== 16'h0000) begin
            bad++; $display("FAIL reset_out_word got=%h/%h required=0000", bus0.out_word, bus1.out_word);
        end
        total++;
        if (bus0.bit_cnt !== 5'd0 || bus1.bit_cnt !== 5'd0) begin
            bad++; $display("FAIL reset_bit_cnt got=%0d/%0d required=0", bus0.bit_cnt, bus1.bit_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        total++;
        if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b/%b required=1", bus0.in_ready, bus1.in_ready);
        end
        total++;
        if (bus0.state !== ST_FILL || bus1.state !== ST_FILL) begin
            bad++; $display("FAIL reset_state got=%0d/%0d required=%0d", bus0.state, bus1.state, ST_FILL);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        push_exp(16'h1234);
        send_word(16'h1234, 0);
        total++;
        if (bus0.bit_cnt !== 5'd16 || bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_pending got cnt=%0d ready=%b valid=%b required cnt=16 ready=0 valid=0",
                     bus0.bit_cnt, bus0.in_ready, bus0.out_valid);
        end
        tick();
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_word !== 16'h1234) begin
            bad++; $display("FAIL basic_lsb_word got valid=%b word=%h required valid=1 word=1234", bus0.out_valid, bus0.out_word);
        end
        total++;
        if (bus1.out_valid !== 1'b1 || bus1.out_word !== 16'h2C48) begin
            bad++; $display("FAIL basic_msb_word got valid=%b word=%h required valid=1 word=2c48", bus1.out_valid, bus1.out_word);
        end
        total++;
        if (bus0.bit_cnt !== 5'd0 || bus1.bit_cnt !== 5'd0) begin
            bad++; $display("FAIL basic_cnt_cleared got=%0d/%0d required=0", bus0.bit_cnt, bus1.bit_cnt);
        end
        tick();
        total++;
        if (bus0.out_valid !== 1'b0 || bus0.out_word !== 16'h1234) begin
            bad++; $display("FAIL basic_drained got valid=%b word=%h required valid=0 word=1234", bus0.out_valid, bus0.out_word);
        end
        wait_drain("basic");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push_exp(16'h00FF);
        push_exp(16'hBEEF);
        push_exp(16'hCAFE);
        send_word(16'h00FF, 0);
        send_word(16'hBEEF, 0);
        tick();
        total++;
        if (bus0.in_ready !== 1'b0 || bus0.bit_cnt !== 5'd16) begin
            bad++; $display("FAIL bp_hold got ready=%b cnt=%0d required ready=0 cnt=16", bus0.in_ready, bus0.bit_cnt);
        end
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus0.out_valid !== 1'b1 || bus0.out_word !== 16'h00FF || bus1.out_word !== 16'hFF00 ||
                bus0.bit_cnt !== 5'd16) begin
                bad++;
                $display("FAIL bp_stable got valid=%b word=%h/%h cnt=%0d required valid=1 word=00ff/ff00 cnt=16",
                         bus0.out_valid, bus0.out_word, bus1.out_word, bus0.bit_cnt);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_word !== 16'hBEEF || bus1.out_word !== 16'hF77D) begin
            bad++;
            $display("FAIL bp_no_gap got valid=%b word=%h/%h required valid=1 word=beef/f77d",
                     bus0.out_valid, bus0.out_word, bus1.out_word);
        end
        total++;
        if (bus0.bit_cnt !== 5'd0 || bus0.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_refill got cnt=%0d ready=%b required cnt=0 ready=1", bus0.bit_cnt, bus0.in_ready);
        end
        send_word(16'hCAFE, 0);
        wait_drain("backpressure");
    endtask

    task automatic test_flush();
        logic [6:0] part;
        out_ready = 1'b1;
        part = 7'b1101101;
        for (int i = 0; i < 7; i++) send_bit(part[i]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (bus0.bit_cnt !== 5'd0 || bus0.out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_partial got cnt=%0d valid=%b required cnt=0 valid=0", bus0.bit_cnt, bus0.out_valid);
        end
        push_exp(16'hA5A5);
        send_word(16'hA5A5, 0);
        wait_drain("flush_a5a5");

        send_word(16'h7E81, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (bus0.bit_cnt !== 5'd0 || bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_pending got cnt=%0d valid=%b/%b required cnt=0 valid=0",
                     bus0.bit_cnt, bus0.out_valid, bus1.out_valid);
        end
        repeat (2) tick();
        total++;
        if (bus0.out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_pending_late got valid=%b required=0", bus0.out_valid);
        end

        for (int i = 0; i < 5; i++) send_bit(1'b1);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        total++;
        if (bus0.bit_cnt !== 5'd0 || bus1.bit_cnt !== 5'd0) begin
            bad++; $display("FAIL flush_with_bit got cnt=%0d/%0d required=0", bus0.bit_cnt, bus1.bit_cnt);
        end
        push_exp(16'h0F0F);
        send_word(16'h0F0F, 0);
        wait_drain("flush_0f0f");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_word(16'h5555, 0);
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_word !== 16'h5555 || bus0.bit_cnt !== 5'd9) begin
            bad++;
            $display("FAIL rstmid_before got valid=%b word=%h cnt=%0d required valid=1 word=5555 cnt=9",
                     bus0.out_valid, bus0.out_word, bus0.bit_cnt);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus0.out_valid !== 1'b0 || bus0.out_word !== 16'h0000 || bus1.out_word !== 16'h0000 ||
            bus0.bit_cnt !== 5'd0) begin
            bad++;
            $display("FAIL rstmid_async got valid=%b word=%h/%h cnt=%0d required valid=0 word=0000 cnt=0",
                     bus0.out_valid, bus0.out_word, bus1.out_word, bus0.bit_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        push_exp(16'h3C96);
        send_word(16'h3C96, 0);
        wait_drain("reset_mid");
        repeat (3) tick();
    endtask

    task automatic test_soak();
        logic [15:0] wd;
        bit          soak_on;
        soak_on   = 1'b1;
        out_ready = 1'b1;
        fork
            begin
                for (int w = 0; w < 40; w++) begin
                    wd = 16'($urandom_range(0, 65535));
                    push_exp(wd);
                    send_word(wd, 2);
                end
                soak_on = 1'b0;
            end
            begin
                while (soak_on) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("soak");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serdes_rx16.md
Name: serdes_rx16

Overview:
- Serial-to-parallel receiver for the 16-bit bit-order path.
- Accepts a 1-bit stream under a valid/ready handshake and assembles 16-bit words.
- Bit order is selected by parameter, so the same block receives LSB-first or MSB-first streams; the MSB-first case performs the 16-bit bit reversal in the receive direction.
- Sits between a serial link or bus pin and the 16-bit register file / word bus of SCM16.

Parameters:
- UUID, 0, instance identifier; not used by the logic.
- NAME, "", instance label; not used by the logic.
- MSB_FIRST, 0, 0 = first received bit lands in out_word[0]; 1 = first received bit lands in out_word[15].

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  serial bit present.
- in_bit  input  1  serial data bit.
- in_ready  output  1  receiver can accept a bit this cycle.
- flush  input  1  synchronous discard of the partially assembled word.
- out_valid  output  1  out_word holds a complete word.
- out_word  output  16  assembled word; stable while out_valid=1 and out_ready=0.
- out_ready  input  1  consumer takes the word.
- bit_cnt  output  5  bits held in the shift stage, 0..16.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-low. While rst=0: shift register=0, bit_cnt=0, out_word=0, out_valid=0. in_ready therefore reads 1 once rst releases.
  - A reset mid-word or mid-hold discards all data with no partial output.
- Storage:
  - Shift stage: sh[15:0] plus cnt[4:0].
  - Output slot: out_word plus out_valid.
- Input side:
  - in_ready = (cnt != 16). It is combinational from registered state only; there is no path from out_ready.
  - A bit is accepted when in_valid & in_ready & !flush.
  - Accepted bit is written to index cnt when MSB_FIRST=0, or to index 15-cnt when MSB_FIRST=1.
  - cnt increments on each accepted bit.
- Shift-stage states:
  - FILL (cnt 0..15) moves to PENDING on the 16th accepted bit.
  - PENDING (cnt=16) moves back to FILL on transfer.
- Transfer:
  - Occurs when cnt=16 & (!out_valid | out_ready) & !flush.
  - Action: out_word <= sh, out_valid <= 1, cnt <= 0, sh <= 0.
- Latency:
  - 16th bit accepted in cycle N gives cnt=16 in N+1, and out_valid=1 in N+2 if the slot is free.
  - in_ready is low for at least cycle N+1, so sustained throughput is 16 bits per 17 cycles.
- Output side:
  - When out_valid & out_ready and no transfer occurs that cycle, out_valid <= 0; out_word keeps its last value.
  - When out_ready and a transfer coincide, the new word replaces the old one with out_valid staying 1 (back-to-back, no bubble on the output side).
- Backpressure: with the slot full and out_ready=0, the block holds in PENDING with in_ready=0 indefinitely. No data is lost and out_word is stable.
- Flush rules:
  - flush=1 sets sh <= 0 and cnt <= 0.
  - flush has priority over bit accept (the bit is dropped) and over transfer (a completed PENDING word is discarded).
  - flush never touches out_word or out_valid.
- Other boundaries:
  - in_valid while in_ready=0: no effect; the upstream must hold the bit.
  - cnt never exceeds 16.
  - in_bit is ignored when in_valid=0.

Decomposition:
- Shared package scm16_pkg:
  - localparam WORD_W=16 and CNT_W=5.
  - Functions: bitrev16 (reuse for any software-side/golden model), and the write-index function idx(cnt, msb_first).
- One natural sub-module, serdes_rx16_slot: a 16-bit valid/ready holding register implementing the output slot (load, stall, simultaneous load-and-drain). The shift stage and counter stay in the top module.

Test Plan:
- Basic LSB-first: MSB_FIRST=0, out_ready=1, stream 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 on consecutive cycles -> out_word=0x1234, out_valid=1 for one cycle, two cycles after the last bit; bit_cnt returns to 0.
- Bit reversal: MSB_FIRST=1, same stream -> out_word=0x2C48 (bitrev16 of 0x1234).
- Backpressure:
  - Stimulus: out_ready=0, send 0x00FF then 32 more bits (0xBEEF, 0xCAFE).
  - Required response: after the second word completes, in_ready=0 and bit_cnt=16; out_word holds 0x00FF, stable.
  - Release out_ready -> 0x00FF, then 0xBEEF on the next cycle (no gap), then 0xCAFE.
- Flush:
  - Flush after 7 bits, then send 0xA5A5 -> out_word=0xA5A5.
  - Flush asserted in the PENDING cycle -> no output and bit_cnt=0.
  - Flush coincident with a bit -> the bit is dropped.
- Reset mid-operation: drop rst for one cycle after 9 bits, with a word held in the slot -> out_valid=0, out_word=0, bit_cnt=0 immediately (asynchronous); the next 16 bits produce exactly one correct word.
- Random soak: random in_valid/out_ready against a scoreboard using bitrev16 for MSB_FIRST=1 -> no loss, no duplication, order preserved, and in_ready is never asserted with bit_cnt=16.
